// File: rtl/console_pkg.sv
// Shared constants and types for the MMIO console UART.
package console_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEFAULT = 32'h0020_0000;
  localparam logic [31:0] FINISH_ADDR_DEFAULT  = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/mmio_console_uart_if.sv
// DCCM write-port snoop bundle: the core drives it, the console observes it.
interface mmio_console_uart_if #(
  parameter int XLEN = 32
);

  logic            dccm_wen;
  logic [XLEN-1:0] dccm_waddr;
  logic [XLEN-1:0] dccm_wdata;

  modport master (output dccm_wen, dccm_waddr, dccm_wdata);
  modport slave  (input  dccm_wen, dccm_waddr, dccm_wdata);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push while full or a pop while empty is ignored;
// dropping policy and accounting live with the caller.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_console_uart.sv
// Snoops core stores: console bytes are queued and sent as UART 8N1,
// a finish store latches a sticky flag and its code. Never back-pressures.
module mmio_console_uart
  import console_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] CONSOLE_ADDR = XLEN'(CONSOLE_ADDR_DEFAULT),
  parameter logic [XLEN-1:0] FINISH_ADDR  = XLEN'(FINISH_ADDR_DEFAULT),
  parameter int              FIFO_DEPTH   = 16,
  parameter int              CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                rst_n,
  mmio_console_uart_if.slave  bus,
  output logic                uart_tx,
  output logic                tx_busy,
  output logic                fifo_full,
  output logic [15:0]         drop_count,
  output logic                finish,
  output logic [XLEN-1:0]     finish_code
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic              console_hit;
  logic              finish_hit;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [7:0]        fifo_dout;
  logic [CNT_W-1:0]  fifo_count;

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  assign console_hit = bus.dccm_wen && (bus.dccm_waddr == CONSOLE_ADDR);
  assign finish_hit  = bus.dccm_wen && (bus.dccm_waddr == FINISH_ADDR);
  assign uart_tx     = tx_q;
  assign tx_busy     = (state_q != IDLE) || (fifo_count != '0);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (console_hit),
    .din   (bus.dccm_wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Count console bytes lost to a full FIFO (registered full, pop ignored).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (console_hit && fifo_full && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // Capture only the first finish store; later ones are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finish      <= 1'b0;
      finish_code <= '0;
    end else if (finish_hit && !finish) begin
      finish      <= 1'b1;
      finish_code <= bus.dccm_wdata;
    end
  end

  // UART control state; tx is a flop so the line never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Shift register holds payload only; it is always loaded before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // Next state and next line level; tx_d is the level for the coming cycle.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = 1'b1;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d  = START;
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          tx_d     = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_q == BAUD_LAST) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_q == BAUD_LAST) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
